seg7_scan: RTL and testbench

Parametrised multiplexed seven-segment display driver: latches an N-digit hexadecimal value, time-multiplexes it onto one shared set of active-low cathodes (CA–CG, DP) and per-digit active-low anodes (AN), and supports per-digit decimal points, per-digit blanking and leading-zero suppression. It generalises the fixed all-digits-show-"0" static driver to a scanned, loadable, N-digit display and sits between user logic and the board's display pins.

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/seg7_hex_decode.sv | 39 +++
 rtl/seg7_scan.sv | 147 ++++++++++++++
 tb/tb_seg7_scan.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the multiplexed seven-segment driver.
//   SEG_0..SEG_F : active-low segment patterns, bit order {a,b,c,d,e,f,g}
//   SEG_OFF      : all segments dark
//   clog2()      : counter width helper, never returns less than 1
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b1100000;  // lower-case b
    localparam logic [6:0] SEG_C   = 7'b0110001;
    localparam logic [6:0] SEG_D   = 7'b1000010;  // lower-case d
    localparam logic [6:0] SEG_E   = 7'b0110000;
    localparam logic [6:0] SEG_F   = 7'b0111000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Width needed to hold 0..n-1; a single-value counter still gets one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex nibble to active-low seven-segment pattern.
//   i_nibble : 4-bit hex digit
//   o_seg    : {a,b,c,d,e,f,g}, 0 = segment lit
// -----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // NOTE: a default ahead of the case keeps this purely combinational; any
    // path that left o_seg unassigned would infer a latch.
    always_comb begin
        o_seg = SEG_OFF;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
// Scanned N-digit hex display driver with per-digit decimal point, per-digit
// blanking and leading-zero suppression. All pins are registered.
//   clk, rst        : clock, synchronous active-high reset
//   load            : capture value/dp/blank/lz_en into the shadow registers
//   value           : nibble i drives digit i (digit 0 rightmost)
//   dp, blank       : per-digit decimal point (1 = lit) and force-dark (1)
//   lz_en           : suppress leading zeros (digit 0 always shown)
//   CA..CG, DP      : shared active-low cathodes
//   AN              : active-low anodes, at most one low
//   scan_tick       : one-cycle pulse after each digit advance
// -----------------------------------------------------------------------------
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_en,
    output logic                    CA,
    output logic                    CB,
    output logic                    CC,
    output logic                    CD,
    output logic                    CE,
    output logic                    CF,
    output logic                    CG,
    output logic                    DP,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    scan_tick
);

    localparam int IDX_W   = clog2(NUM_DIGITS);
    localparam int PRESC_W = clog2(CLK_DIV);

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    // Scan state
    logic [PRESC_W-1:0] r_presc;
    logic [IDX_W-1:0]   r_idx;

    // Shadow registers, stored as a nibble array for direct digit indexing
    logic [NUM_DIGITS-1:0][3:0] r_val;
    logic [NUM_DIGITS-1:0]      r_dp;
    logic [NUM_DIGITS-1:0]      r_blank;
    logic                       r_lz;

    // Output registers
    logic [6:0]            r_seg;
    logic                  r_dp_n;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_tick;

    logic                  w_tc;
    logic [NUM_DIGITS-1:0] w_zero_above;
    logic                  w_blank_sel;
    logic [6:0]            w_dec_seg;
    logic [6:0]            w_seg;
    logic                  w_dp_n;
    logic [NUM_DIGITS-1:0] w_an;

    assign w_tc = (r_presc == PRESC_LAST);

    // w_zero_above[i]: nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is
    // excluded so a value of zero still shows a single "0".
    always_comb begin
        logic w_all_zero;
        w_all_zero   = 1'b1;
        w_zero_above = '0;
        // NOTE: blocking assignments here build a running AND from the top
        // digit down within one evaluation; state elsewhere uses <=.
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_all_zero      = w_all_zero & (r_val[i] == 4'h0);
            w_zero_above[i] = w_all_zero;
        end
    end

    assign w_blank_sel = r_blank[r_idx] | (r_lz & w_zero_above[r_idx]);

    seg7_hex_decode u_dec (
        .i_nibble (r_val[r_idx]),
        .o_seg    (w_dec_seg)
    );

    always_comb begin
        w_an   = '1;
        w_seg  = SEG_OFF;
        w_dp_n = 1'b1;
        if (!w_blank_sel) begin
            w_an[r_idx] = 1'b0;
            w_seg       = w_dec_seg;
            w_dp_n      = ~r_dp[r_idx];
        end
    end

    // NOTE: the shadow registers are a handful of flops rather than a RAM, so
    // they take the reset like everything else and the display is defined
    // from the first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_val   <= '0;
            r_dp    <= '0;
            r_blank <= '0;
            r_lz    <= 1'b0;
            r_seg   <= SEG_OFF;
            r_dp_n  <= 1'b1;
            r_an    <= '1;
            r_tick  <= 1'b0;
        end else begin
            if (w_tc) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            // All four shadows move together so a frame never mixes old and
            // new data.
            if (load) begin
                r_val   <= value;
                r_dp    <= dp;
                r_blank <= blank;
                r_lz    <= lz_en;
            end

            r_seg  <= w_seg;
            r_dp_n <= w_dp_n;
            r_an   <= w_an;
            r_tick <= w_tc;
        end
    end

    assign {CA, CB, CC, CD, CE, CF, CG} = r_seg;
    assign DP        = r_dp_n;
    assign AN        = r_an;
    assign scan_tick = r_tick;

endmodule

// File: tb/tb_seg7_scan.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan
// Directed bench for seg7_scan: a 4-digit instance with CLK_DIV=4 and a
// 1-digit instance with CLK_DIV=2 share clock and reset. Outputs are sampled
// on the falling edge; inputs change on the falling edge.
// Packed observation: {AN, CA..CG, DP, scan_tick}.
// -----------------------------------------------------------------------------
module tb_seg7_scan;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_en;
    logic        ca, cb, cc, cd, ce, cf, cg, dp_pin;
    logic [3:0]  an;
    logic        scan_tick;

    logic        load1;
    logic [3:0]  value1;
    logic        dp1;
    logic        blank1;
    logic        lz1;
    logic        ca1, cb1, cc1, cd1, ce1, cf1, cg1, dp_pin1;
    logic        an1;
    logic        tick1;

    int total;
    int bad;

    seg7_scan #(.NUM_DIGITS(4), .CLK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .value     (value),
        .dp        (dp),
        .blank     (blank),
        .lz_en     (lz_en),
        .CA        (ca),
        .CB        (cb),
        .CC        (cc),
        .CD        (cd),
        .CE        (ce),
        .CF        (cf),
        .CG        (cg),
        .DP        (dp_pin),
        .AN        (an),
        .scan_tick (scan_tick)
    );

    seg7_scan #(.NUM_DIGITS(1), .CLK_DIV(2)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .load      (load1),
        .value     (value1),
        .dp        (dp1),
        .blank     (blank1),
        .lz_en     (lz1),
        .CA        (ca1),
        .CB        (cb1),
        .CC        (cc1),
        .CD        (cd1),
        .CE        (ce1),
        .CF        (cf1),
        .CG        (cg1),
        .DP        (dp_pin1),
        .AN        (an1),
        .scan_tick (tick1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pk(input logic [3:0] a, input logic [6:0] s,
                                       input logic d, input logic t);
        return {3'b000, a, s, d, t};
    endfunction

    function automatic logic [15:0] pk1(input logic a, input logic [6:0] s,
                                        input logic d, input logic t);
        return {6'b000000, a, s, d, t};
    endfunction

    function automatic logic [15:0] obs();
        return {3'b000, an, ca, cb, cc, cd, ce, cf, cg, dp_pin, scan_tick};
    endfunction

    function automatic logic [15:0] obs1();
        return {6'b000000, an1, ca1, cb1, cc1, cd1, ce1, cf1, cg1, dp_pin1, tick1};
    endfunction

    // Advance n rising edges, then settle on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        step(2);
        rst  = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        load   = 1'b0;
        value  = 16'h0000;
        dp     = 4'b0000;
        blank  = 4'b0000;
        lz_en  = 1'b0;
        load1  = 1'b1;
        value1 = 4'h7;
        dp1    = 1'b1;
        blank1 = 1'b0;
        lz1    = 1'b1;

        // Reset held 3 cycles
        step(3);
        check("reset", obs(), pk(4'b1111, 7'b1111111, 1'b1, 1'b0));
        check("reset_n1", obs1(), pk1(1'b1, 7'b1111111, 1'b1, 1'b0));

        // Scan of 12AF
        rst = 1'b0; load = 1'b1; value = 16'h12AF;
        step(1);
        check("scan_first_old", obs(), pk(4'b1110, 7'b0000001, 1'b1, 1'b0));
        load = 1'b0;
        step(1);
        check("scan_d0_F", obs(), pk(4'b1110, 7'b0111000, 1'b1, 1'b0));
        check("n1_digit7_tick", obs1(), pk1(1'b0, 7'b0001111, 1'b0, 1'b1));
        step(1);
        check("n1_tick_low", obs1(), pk1(1'b0, 7'b0001111, 1'b0, 1'b0));
        step(1);
        check("scan_tick_d0", obs(), pk(4'b1110, 7'b0111000, 1'b1, 1'b1));
        check("n1_tick_again", obs1(), pk1(1'b0, 7'b0001111, 1'b0, 1'b1));
        step(1);
        check("scan_d1_A", obs(), pk(4'b1101, 7'b0001000, 1'b1, 1'b0));
        step(4);
        check("scan_d2_2", obs(), pk(4'b1011, 7'b0010010, 1'b1, 1'b0));
        step(4);
        check("scan_d3_1", obs(), pk(4'b0111, 7'b1001111, 1'b1, 1'b0));
        step(3);
        check("scan_d3_last", obs(), pk(4'b0111, 7'b1001111, 1'b1, 1'b1));
        step(1);
        check("scan_wrap_d0", obs(), pk(4'b1110, 7'b0111000, 1'b1, 1'b0));

        // DP and blanking on 8888
        do_reset();
        load = 1'b1; value = 16'h8888; dp = 4'b0100; blank = 4'b0001;
        step(1);
        load = 1'b0;
        step(1);
        check("blank_d0", obs(), pk(4'b1111, 7'b1111111, 1'b1, 1'b0));
        step(3);
        check("dp_d1_off", obs(), pk(4'b1101, 7'b0000000, 1'b1, 1'b0));
        step(4);
        check("dp_d2_on", obs(), pk(4'b1011, 7'b0000000, 1'b0, 1'b0));
        step(4);
        check("dp_d3_off", obs(), pk(4'b0111, 7'b0000000, 1'b1, 1'b0));

        // Leading-zero suppression
        do_reset();
        load = 1'b1; value = 16'h0050; dp = 4'b0000; blank = 4'b0000; lz_en = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        check("lz_d0_zero", obs(), pk(4'b1110, 7'b0000001, 1'b1, 1'b0));
        step(3);
        check("lz_d1_five", obs(), pk(4'b1101, 7'b0100100, 1'b1, 1'b0));
        step(4);
        check("lz_d2_dark", obs(), pk(4'b1111, 7'b1111111, 1'b1, 1'b0));
        step(4);
        check("lz_d3_dark", obs(), pk(4'b1111, 7'b1111111, 1'b1, 1'b0));
        load = 1'b1; value = 16'h0000;
        step(1);
        load = 1'b0;
        step(3);
        check("lz0_d0_zero", obs(), pk(4'b1110, 7'b0000001, 1'b1, 1'b0));
        step(4);
        check("lz0_d1_dark", obs(), pk(4'b1111, 7'b1111111, 1'b1, 1'b0));

        // Load at terminal count, then mid-frame reset
        do_reset();
        load = 1'b1; value = 16'hFFFF; lz_en = 1'b0;
        step(1);
        load = 1'b0;
        step(2);
        check("tc_pre", obs(), pk(4'b1110, 7'b0111000, 1'b1, 1'b0));
        load = 1'b1; value = 16'h0001;
        step(1);
        check("tc_edge_old", obs(), pk(4'b1110, 7'b0111000, 1'b1, 1'b1));
        load = 1'b0;
        step(1);
        check("tc_new_d1", obs(), pk(4'b1101, 7'b0000001, 1'b1, 1'b0));
        step(4);
        check("tc_new_d2", obs(), pk(4'b1011, 7'b0000001, 1'b1, 1'b0));
        rst = 1'b1; load = 1'b1; value = 16'hABCD;
        step(1);
        check("midrst", obs(), pk(4'b1111, 7'b1111111, 1'b1, 1'b0));
        rst = 1'b0; load = 1'b0;
        step(1);
        check("midrst_restart", obs(), pk(4'b1110, 7'b0000001, 1'b1, 1'b0));
        step(3);
        check("midrst_tick", obs(), pk(4'b1110, 7'b0000001, 1'b1, 1'b1));
        step(1);
        check("midrst_d1", obs(), pk(4'b1101, 7'b0000001, 1'b1, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
